// File: rtl/slave_resp_collector_if.sv
// Master <-> collector bundle: request side, slave return path and response.
//
// Handshake: the master raises req_valid for one cycle while busy = 0. The
// request is taken on that edge, busy rises the next cycle, and req_valid is
// ignored until resp_valid has pulsed for exactly one cycle. There is no
// backpressure on the response; the master must take it on the cycle
// resp_valid is high. Each slave signals completion with a slave_ready pulse
// while its read data is driven on its slice of slave_rdata.
interface slave_resp_collector_if #(
   parameter int DATA_W = 32
);
   logic                  req_valid;
   logic                  req_write;
   logic [3:0]            slave_en;
   logic [3:0]            slave_ready;
   logic [4*DATA_W-1:0]   slave_rdata;
   logic                  resp_valid;
   logic [DATA_W-1:0]     resp_rdata;
   logic                  resp_error;
   logic [1:0]            resp_slave;
   logic                  busy;

   // Collector side of the bundle.
   modport slave (
      input  req_valid, req_write, slave_en, slave_ready, slave_rdata,
      output resp_valid, resp_rdata, resp_error, resp_slave, busy
   );

   // Master / environment side of the bundle.
   modport master (
      output req_valid, req_write, slave_en, slave_ready, slave_rdata,
      input  resp_valid, resp_rdata, resp_error, resp_slave, busy
   );
endinterface

// File: rtl/slave_resp_collector.sv
// Response collector for the address decode logic: latches the selected
// slave on a request, waits for that slave's ready (bounded by TIMEOUT) and
// returns a registered single-cycle response. Non-one-hot selects are
// answered immediately with an error.
module slave_resp_collector #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   slave_resp_collector_if.slave  bus,
   output logic [1:0]             dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          sel_q, sel_d;
   logic                wr_q, wr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
   logic                resp_error_q, resp_error_d;
   logic [1:0]          resp_slave_q, resp_slave_d;

   logic                en_onehot;
   logic [1:0]          idx;
   logic                ready_sel;
   logic                timeout_hit;
   logic [DATA_W-1:0]   sel_rdata;

   // A select is legal only when exactly one enable bit is set.
   assign en_onehot   = (bus.slave_en != 4'd0) &&
                        ((bus.slave_en & (bus.slave_en - 4'd1)) == 4'd0);
   assign ready_sel   = bus.slave_ready[idx];
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

   // Encode the latched one-hot select into a slave index.
   always_comb begin
      idx = 2'd0;
      case (sel_q)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
   end

   // Pick the read-data slice of the latched slave.
   always_comb begin
      sel_rdata = bus.slave_rdata[0 +: DATA_W];
      case (idx)
         2'd0: sel_rdata = bus.slave_rdata[0*DATA_W +: DATA_W];
         2'd1: sel_rdata = bus.slave_rdata[1*DATA_W +: DATA_W];
         2'd2: sel_rdata = bus.slave_rdata[2*DATA_W +: DATA_W];
         2'd3: sel_rdata = bus.slave_rdata[3*DATA_W +: DATA_W];
         default: sel_rdata = '0;
      endcase
   end

   // State register; reset abandons any transfer in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: bad selects skip WAIT, ready beats timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               state_d = en_onehot ? ST_WAIT : ST_RESP;
            end
         end
         ST_WAIT: begin
            if (ready_sel || timeout_hit) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output/datapath next values; response fields hold between responses.
   always_comb begin
      sel_d        = sel_q;
      wr_d         = wr_q;
      cnt_d        = cnt_q;
      resp_rdata_d = resp_rdata_q;
      resp_error_d = resp_error_q;
      resp_slave_d = resp_slave_q;
      resp_valid_d = (state_d == ST_RESP);
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               sel_d = bus.slave_en;
               wr_d  = bus.req_write;
               cnt_d = '0;
               if (!en_onehot) begin
                  resp_rdata_d = '0;
                  resp_error_d = 1'b1;
                  resp_slave_d = 2'd0;
               end
            end
         end
         ST_WAIT: begin
            if (ready_sel) begin
               resp_error_d = 1'b0;
               resp_slave_d = idx;
               resp_rdata_d = wr_q ? '0 : sel_rdata;
            end else if (timeout_hit) begin
               resp_error_d = 1'b1;
               resp_slave_d = idx;
               resp_rdata_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath and registered response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q        <= 4'd0;
         wr_q         <= 1'b0;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_error_q <= 1'b0;
         resp_slave_q <= 2'd0;
      end else begin
         sel_q        <= sel_d;
         wr_q         <= wr_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_error_q <= resp_error_d;
         resp_slave_q <= resp_slave_d;
      end
   end

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_error = resp_error_q;
   assign bus.resp_slave = resp_slave_q;
   assign bus.busy       = (state_q != ST_IDLE);
   assign dbg_state_o    = state_q;

endmodule

// File: doc/slave_resp_collector.md
Name: slave_resp_collector

Overview:
Return-path companion to the address decode logic (ADL). The ADL fans a master address out to one of four slave enables; this block closes the loop on the response side. It latches which slave was selected when the master issues a transfer, waits for that slave's ready, and routes its read data back to the master as a single-cycle response. A timeout counter flags slaves that never answer, and a check rejects non-one-hot enables.

Parameters:
DATA_W, 32, width of each slave read-data bus and of the response data
TIMEOUT, 16, maximum WAIT cycles before an error response; legal range 2..255
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  master starts a transfer this cycle; sampled only in IDLE
req_write  input  1  1 = write transfer, 0 = read; sampled with req_valid
slave_en  input  4  one-hot slave select from the ADL; bit i maps to address[31:30] == i
slave_ready  input  4  per-slave completion strobe
slave_rdata  input  4*DATA_W  packed read data; slave i occupies bits [i*DATA_W +: DATA_W]
resp_valid  output  1  one-cycle response strobe to the master
resp_rdata  output  DATA_W  read data, valid when resp_valid = 1
resp_error  output  1  error flag, valid when resp_valid = 1
resp_slave  output  2  index of the responding slave, valid when resp_valid = 1
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: all of the following are cleared on the rising edge of clk while rst = 1, and rst overrides every other input.
  - State returns to IDLE.
  - resp_valid = 0, resp_rdata = 0, resp_error = 0, resp_slave = 0, busy = 0.
  - Counter, latched select and latched write flag are cleared.
  - Reset mid-transfer abandons the transfer; no response is ever issued for it.
- States: IDLE, WAIT, RESP. All outputs are registered.
- IDLE, on req_valid = 1:
  - Latch sel = slave_en and wr = req_write.
  - If slave_en is exactly one-hot: clear the counter and go to WAIT.
  - If slave_en is 0000 or has more than one bit set: go directly to RESP with resp_error = 1, resp_rdata = 0, resp_slave = 0.
- WAIT: only the latched slave matters. slave_ready bits of other slaves are ignored, and changes on slave_en are ignored.
  - If slave_ready[idx] = 1: go to RESP with resp_error = 0 and resp_slave = idx. resp_rdata = slave_rdata of slave idx for a read, 0 for a write.
  - Else if counter == TIMEOUT-1: go to RESP with resp_error = 1, resp_rdata = 0, resp_slave = idx.
  - Else: counter increments by 1.
  - Ready and timeout in the same cycle: ready wins, no error.
- RESP: resp_valid = 1 for exactly one cycle, then return to IDLE.
  - resp_rdata, resp_error and resp_slave hold their values after RESP until the next response; only resp_valid drops.
- Request rules:
  - req_valid is ignored while busy = 1. No queueing; the master must wait for resp_valid.
  - A new req_valid in the first IDLE cycle after RESP is accepted, giving back-to-back throughput of one transfer every 3 or more cycles.
- Latency, with req_valid sampled at edge k:
  - busy = 1 from cycle k+1.
  - If the selected slave's ready is high in cycle k+1, resp_valid is high in cycle k+2. This is the minimum latency.
  - A slave that never answers gives resp_valid in cycle k+TIMEOUT+1.
  - A bad select gives resp_valid in cycle k+1.
- Index encoding: idx = 0,1,2,3 for sel = 0001, 0010, 0100, 1000.

Test Plan:
- Reset, then idle 3 cycles → every output is 0 and busy = 0.
- Read to slave 1: slave_en = 0010 (address 0x40000000), req_write = 0. slave_ready = 0010 one cycle later, slave 1 data = 0xDEADBEEF, other slaves' data = 0x11111111 → resp_valid high for exactly 1 cycle, 2 cycles after the request. resp_rdata = 0xDEADBEEF, resp_error = 0, resp_slave = 1.
- Write to slave 3 (slave_en = 1000): slave_ready = 0001 is held throughout (wrong slave), then slave_ready = 1000 arrives after 5 WAIT cycles → response with resp_error = 0, resp_slave = 3, resp_rdata = 0. A req_valid pulsed during WAIT is ignored and busy stays 1.
- Timeout, TIMEOUT = 16: read to slave 2 with no ready ever → resp_valid exactly 17 cycles after the request, resp_error = 1, resp_slave = 2, resp_rdata = 0. Then ready and the final timeout cycle coincide on a second transfer → resp_error = 0.
- Bad select: slave_en = 0000, then slave_en = 0110 → each gives resp_valid 1 cycle after the request with resp_error = 1.
- Reset mid-operation: rst asserted in the 3rd WAIT cycle, then slave_ready pulses after reset → no resp_valid, and state is IDLE. A fresh read to slave 0 (slave_en = 0001, data 0x00000042) then completes normally.
